// File: rtl/temporal_encoder.sv
// rtl/temporal_encoder.sv - temporal spike encoder with one-deep pending buffer and gamma cycle counter
module temporal_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int VW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic          aclk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [VW-1:0] in_value,
  input  logic [1:0]    in_mode,
  input  logic          in_null,
  output logic          q,
  output logic          gamma_start,
  output logic [VW-1:0] gamma_cnt,
  output logic [7:0]    miss_cnt
);

  localparam logic [VW-1:0] LP_LAST    = VW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [1:0]    MODE_FALL  = 2'd1;
  localparam logic [1:0]    MODE_PULSE = 2'd2;

  logic [VW-1:0] r_gamma_cnt;
  logic          r_pend_valid;
  logic [VW-1:0] r_pend_value;
  logic [1:0]    r_pend_mode;
  logic          r_pend_null;
  logic [VW-1:0] r_act_value;
  logic [1:0]    r_act_mode;
  logic          r_act_null;
  logic [7:0]    r_miss_cnt;
  logic          r_q;

  logic          w_wrap;
  logic          w_xfer;
  logic [VW-1:0] w_cnt_next;
  logic [VW-1:0] w_act_value_next;
  logic [1:0]    w_act_mode_next;
  logic          w_act_null_next;
  logic [31:0]   w_c32;
  logic [31:0]   w_v32;
  logic          w_spike;
  logic          w_reached;
  logic          w_in_pulse;
  logic          w_q_next;

  assign w_wrap      = (r_gamma_cnt == LP_LAST);
  assign w_xfer      = in_valid && !r_pend_valid;
  assign in_ready    = !r_pend_valid;
  assign q           = r_q;
  assign gamma_cnt   = r_gamma_cnt;
  assign gamma_start = (r_gamma_cnt == '0);
  assign miss_cnt    = r_miss_cnt;

  // Next gamma position and the entry that will be active in the next cycle
  always_comb begin
    w_cnt_next       = w_wrap ? '0 : r_gamma_cnt + VW'(1);
    w_act_value_next = r_act_value;
    w_act_mode_next  = r_act_mode;
    w_act_null_next  = r_act_null;
    if (w_wrap) begin
      if (r_pend_valid) begin
        w_act_value_next = r_pend_value;
        w_act_mode_next  = r_pend_mode;
        w_act_null_next  = r_pend_null;
      end else begin
        w_act_null_next  = 1'b1;
      end
    end
  end

  // Spike level for the next cycle, so q can be registered with no input-to-output path
  always_comb begin
    w_c32      = 32'(w_cnt_next);
    w_v32      = 32'(w_act_value_next);
    w_spike    = !w_act_null_next && (w_v32 < 32'(GAMMA_CYCLE_WIDTH));
    w_reached  = (w_c32 >= w_v32);
    w_in_pulse = (w_c32 < (w_v32 + 32'(PULSE_WIDTH)));
    case (w_act_mode_next)
      MODE_FALL:  w_q_next = !(w_spike && w_reached);
      MODE_PULSE: w_q_next = w_spike && w_reached && w_in_pulse;
      default:    w_q_next = w_spike && w_reached;
    endcase
  end

  // Counter, pending/active entries, miss counter and the spike flop
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_gamma_cnt  <= '0;
      r_pend_valid <= 1'b0;
      r_pend_value <= '0;
      r_pend_mode  <= 2'd0;
      r_pend_null  <= 1'b1;
      r_act_value  <= '0;
      r_act_mode   <= 2'd0;
      r_act_null   <= 1'b1;
      r_miss_cnt   <= 8'd0;
      r_q          <= 1'b0;
    end else begin
      r_gamma_cnt <= w_cnt_next;
      r_act_value <= w_act_value_next;
      r_act_mode  <= w_act_mode_next;
      r_act_null  <= w_act_null_next;
      r_q         <= w_q_next;
      if (w_wrap) begin
        r_pend_valid <= 1'b0;
        if (!r_pend_valid && (r_miss_cnt != 8'hFF)) begin
          r_miss_cnt <= r_miss_cnt + 8'd1;
        end
      end
      // A capture on the wrap edge refills pending for the gamma cycle after next
      if (w_xfer) begin
        r_pend_valid <= 1'b1;
        r_pend_value <= in_value;
        r_pend_mode  <= in_mode;
        r_pend_null  <= in_null;
      end
    end
  end

endmodule

// File: tb/tb_temporal_encoder.sv
// tb/tb_temporal_encoder.sv - self-checking bench for temporal_encoder
module tb_temporal_encoder;

  localparam int G  = 16;
  localparam int P  = 8;
  localparam int VW = 4;

  logic          aclk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_value = '0;
  logic [1:0]    in_mode = 2'd0;
  logic          in_null = 1'b0;
  logic          in_ready;
  logic          q;
  logic          gamma_start;
  logic [VW-1:0] gamma_cnt;
  logic [7:0]    miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model state
  int m_cnt = 0;
  int m_miss = 0;
  bit m_pend_valid = 1'b0;
  int m_pv = 0;
  int m_pm = 0;
  bit m_pn = 1'b1;
  int m_av = 0;
  int m_am = 0;
  bit m_an = 1'b1;

  logic [15:0] bits;

  always #5 aclk = ~aclk;

  temporal_encoder #(
    .GAMMA_CYCLE_WIDTH(G),
    .PULSE_WIDTH(P),
    .VW(VW)
  ) dut (
    .aclk(aclk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_value(in_value),
    .in_mode(in_mode),
    .in_null(in_null),
    .q(q),
    .gamma_start(gamma_start),
    .gamma_cnt(gamma_cnt),
    .miss_cnt(miss_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_q(input int c, input int v, input int mode, input bit nul);
    bit s;
    s = !nul && (v < G);
    case (mode)
      1:       return !(s && (c >= v));
      2:       return s && (c >= v) && (c < v + P);
      default: return s && (c >= v);
    endcase
  endfunction

  // Model advances on every rising edge using the inputs presented to it
  always @(posedge aclk) begin
    bit acc;
    if (rst) begin
      m_cnt = 0; m_miss = 0; m_pend_valid = 0;
      m_an = 1; m_am = 0; m_av = 0;
    end else begin
      acc = in_valid && !m_pend_valid;
      if (m_cnt == G - 1) begin
        if (m_pend_valid) begin
          m_av = m_pv; m_am = m_pm; m_an = m_pn;
        end else begin
          m_an = 1;
          if (m_miss < 255) m_miss = m_miss + 1;
        end
        m_pend_valid = 0;
      end
      if (acc) begin
        m_pend_valid = 1; m_pv = int'(in_value); m_pm = int'(in_mode); m_pn = in_null;
      end
      m_cnt = (m_cnt + 1) % G;
    end
  end

  // Compare DUT outputs against the model every cycle
  always @(negedge aclk) begin
    if (chk_en) begin
      check("q", int'(q), int'(model_q(m_cnt, m_av, m_am, m_an)));
      check("gamma_start", int'(gamma_start), int'(m_cnt == 0));
      check("gamma_cnt", int'(gamma_cnt), m_cnt);
      check("miss_cnt", int'(miss_cnt), m_miss);
      check("in_ready", int'(in_ready), int'(!m_pend_valid));
    end
  end

  task automatic step();
    @(negedge aclk);
  endtask

  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    while ((int'(gamma_cnt) != c) && (n < 64)) begin
      @(negedge aclk);
      n++;
    end
    check("wait_cnt", int'(gamma_cnt), c);
  endtask

  task automatic load(input int v, input int m, input bit nl);
    in_valid = 1'b1;
    in_value = v[VW-1:0];
    in_mode  = m[1:0];
    in_null  = nl;
    @(negedge aclk);
    in_valid = 1'b0;
  endtask

  // Records q over one whole gamma cycle starting at c == 0, optionally offering a value at c == 0
  task automatic capture(output logic [15:0] b, input bit ld, input int v, input int m, input bit nl);
    check("cap_align", int'(gamma_cnt), 0);
    if (ld) begin
      in_valid = 1'b1;
      in_value = v[VW-1:0];
      in_mode  = m[1:0];
      in_null  = nl;
    end
    for (int i = 0; i < G; i++) begin
      b[i] = q;
      if (i < G - 1) begin
        @(negedge aclk);
        if (i == 0) in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    step();
    step();
    chk_en = 1'b1;
    check("rst_gamma_cnt", int'(gamma_cnt), 0);
    check("rst_q", int'(q), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_miss", int'(miss_cnt), 0);
    check("rst_gamma_start", int'(gamma_start), 1);
    rst = 1'b0;

    // Rising v=5 then an empty gamma
    load(5, 0, 0);
    wait_cnt(0);
    capture(bits, 0, 0, 0, 0);
    check("rise5", int'(bits), 16'hFFE0);
    step();
    capture(bits, 0, 0, 0, 0);
    check("rise5_after", int'(bits), 16'h0000);
    check("miss_after_rise", int'(miss_cnt), 1);

    // Falling v=3 then null keeps q high
    step();
    load(3, 1, 0);
    wait_cnt(0);
    capture(bits, 0, 0, 0, 0);
    check("fall3", int'(bits), 16'h0007);
    step();
    capture(bits, 0, 0, 0, 0);
    check("fall_null", int'(bits), 16'hFFFF);

    // Pulse v=2 and truncated pulse v=12
    step();
    load(2, 2, 0);
    wait_cnt(0);
    capture(bits, 0, 0, 0, 0);
    check("pulse2", int'(bits), 16'h03FC);
    step();
    load(12, 2, 0);
    wait_cnt(0);
    capture(bits, 0, 0, 0, 0);
    check("pulse12", int'(bits), 16'hF000);
    step();
    check("pulse12_nowrap", int'(q), 0);
    check("miss_mid", int'(miss_cnt), 6);

    // Transfer on the wrap edge is used one gamma later
    wait_cnt(15);
    load(7, 0, 0);
    check("wrap_ready", int'(in_ready), 0);
    check("wrap_miss", int'(miss_cnt), 7);
    capture(bits, 0, 0, 0, 0);
    check("wrap_null", int'(bits), 16'h0000);
    step();
    capture(bits, 0, 0, 0, 0);
    check("wrap_rise7", int'(bits), 16'hFF80);

    // Back-to-back rising v=0 then pulse v=15
    step();
    load(0, 0, 0);
    wait_cnt(0);
    capture(bits, 1, 15, 2, 0);
    check("b2b_rise0", int'(bits), 16'hFFFF);
    step();
    capture(bits, 0, 0, 0, 0);
    check("b2b_pulse15", int'(bits), 16'h8000);

    // Reset in the middle of a pulse v=4 spike with a value pending
    step();
    load(4, 2, 0);
    wait_cnt(0);
    wait_cnt(5);
    load(1, 0, 0);
    step();
    check("pre_rst_q", int'(q), 1);
    rst = 1'b1;
    step();
    check("mid_rst_q", int'(q), 0);
    check("mid_rst_cnt", int'(gamma_cnt), 0);
    check("mid_rst_miss", int'(miss_cnt), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    rst = 1'b0;
    capture(bits, 1, 10, 3, 0);
    check("post_rst_null", int'(bits), 16'h0000);
    check("post_rst_miss", int'(miss_cnt), 0);

    // Reserved mode behaves as rising; explicit null request
    step();
    capture(bits, 1, 4, 0, 1);
    check("mode3_rise10", int'(bits), 16'hFC00);
    step();
    capture(bits, 0, 0, 0, 0);
    check("in_null", int'(bits), 16'h0000);
    check("final_miss", int'(miss_cnt), 0);

    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/temporal_encoder.md
TEMPORAL_ENCODER -- requirements
Module: temporal_encoder

Interface
REQ-001 Parameter GAMMA_CYCLE_WIDTH, default 16, SHALL set the number of aclk cycles per gamma cycle (>=2).
REQ-002 Parameter PULSE_WIDTH, default 8, SHALL set the high time in aclk cycles of a pulse-width-coded spike (>=1).
REQ-003 Parameter VW, default $clog2(GAMMA_CYCLE_WIDTH), SHALL set the width of the spike-time value.
REQ-004 aclk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 in_valid  input  1  SHALL indicate that in_value/in_mode/in_null are presented.
REQ-007 in_ready  output  1  SHALL indicate that the pending buffer can accept a value.
REQ-008 in_value  input  VW  SHALL be the spike time in aclk cycles from gamma start.
REQ-009 in_mode  input  2  SHALL select the encoding: 0 rising edge, 1 falling edge, 2 pulse width, 3 reserved (treated as 0).
REQ-010 in_null  input  1  SHALL request no spike in the gamma cycle.
REQ-011 q  output  1  SHALL be the registered temporal-coded spike line.
REQ-012 gamma_start  output  1  SHALL be high exactly in the cycle where gamma_cnt == 0.
REQ-013 gamma_cnt  output  VW  SHALL be the current position within the gamma cycle.
REQ-014 miss_cnt  output  8  SHALL count gamma cycles that started with no pending value, saturating at 255.

Function
REQ-015 gamma_cnt SHALL increment by 1 per cycle and wrap from GAMMA_CYCLE_WIDTH-1 to 0.
REQ-016 The block SHALL hold one pending entry {value, mode, null}; in_ready SHALL equal !pend_valid.
REQ-017 A transfer SHALL occur on an edge where in_valid && in_ready; the pending entry is captured and pend_valid set.
REQ-018 On the edge ending gamma_cnt == GAMMA_CYCLE_WIDTH-1, the pending entry SHALL move to the active register and pend_valid SHALL clear.
REQ-019 If pend_valid is 0 at that edge, the active register SHALL become null, keep its previous mode, and miss_cnt SHALL increment (saturating).
REQ-020 A transfer on that same edge SHALL fill pending only; it SHALL NOT be used until the following gamma cycle.
REQ-021 Active in_value >= GAMMA_CYCLE_WIDTH SHALL be treated as null.
REQ-022 Let c be gamma_cnt, v the active value, and s = !active_null. In the cycle with gamma_cnt == c, q SHALL equal the following.
REQ-023 Rising mode: s && (c >= v); q returns to 0 at c == 0 of the next gamma cycle.
REQ-024 Falling mode: !(s && (c >= v)); q returns to 1 at c == 0 of the next gamma cycle.
REQ-025 Pulse mode: s && (v <= c) && (c < v + PULSE_WIDTH); the pulse SHALL truncate at GAMMA_CYCLE_WIDTH-1 and never wrap into the next gamma cycle.
REQ-026 q SHALL be driven from a flip-flop, with no combinational path from any input to q.
REQ-027 The pending entry SHALL be unaffected by the active encoding, so back-to-back gamma cycles can each carry a spike.

Reset
REQ-028 While rst is high at an edge, the following SHALL be set: gamma_cnt = 0, pend_valid = 0, active = null with rising mode, miss_cnt = 0, q = 0.
REQ-029 In the first cycle after rst deasserts, gamma_cnt SHALL be 0, gamma_start SHALL be 1, in_ready SHALL be 1, and that gamma cycle SHALL be null.
REQ-030 rst asserted mid-gamma SHALL discard the pending and active entries; no partial spike SHALL appear after release.
REQ-031 The null gamma cycle after reset SHALL NOT increment miss_cnt.

Verification (G=16, P=8)
REQ-032 Rising, v=5, loaded in gamma 0 -> in gamma 1, q=0 for c=0..4 and q=1 for c=5..15; q=0 at c=0 of gamma 2 if no new value; miss_cnt=1.
REQ-033 Falling, v=3 -> q=1 for c=0..2 and q=0 for c=3..15; null next gamma -> q=1 throughout.
REQ-034 Pulse, v=2 -> q=1 for c=2..9; pulse v=12 -> q=1 for c=12..15 only, q=0 at next c=0.
REQ-035 Transfer on the edge ending c=15 -> next gamma null (miss_cnt+1) and the value emitted one gamma later; in_ready=0 while pending is full.
REQ-036 Back-to-back: rising v=0 then pulse v=15 -> q=1 for all of gamma N; in gamma N+1, q=1 only at c=15.
REQ-037 rst pulsed at c=7 of a pulse v=4 spike -> q=0 in the next cycle, gamma_cnt=0, miss_cnt=0, in_ready=1.
